// File: rtl/dr_frame_packer.sv
// rtl/dr_frame_packer.sv - sample FIFO plus SOF/payload/checksum frame packer on a byte stream
// Optional frame sequence byte after SOF when PACKER_SEQ_EN is defined.
module dr_frame_packer #(
   parameter int         FIFO_DEPTH = 16,
   parameter int         FRAME_LEN  = 4,
   parameter logic [7:0] SOF_BYTE   = 8'hA5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    in_data,
   input  logic                          in_dr,
   output logic [7:0]                    out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          ovf_clr,
   output logic                          busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam logic [LW-1:0] DEPTH_LVL = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] FRAME_LVL = LW'(FRAME_LEN);
   localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_LEN);

`ifdef PACKER_SEQ_EN
   typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_SEQ, ST_PAYLOAD, ST_CSUM} state_t;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_PAYLOAD, ST_CSUM} state_t;
`endif

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          fifo_full;
   logic          wr_en;
   logic          drop;
   logic          pop;
   logic [7:0]    head;

   state_t        state, state_n;
   logic [7:0]    out_data_n;
   logic          out_valid_n;
   logic [7:0]    acc, acc_n;
   logic [7:0]    sum;
   logic [CW-1:0] cnt, cnt_n;
   logic          xfer;
`ifdef PACKER_SEQ_EN
   logic [7:0]    seq, seq_n;
`endif

   // Fullness is judged on the registered level, so a pop in the same cycle never frees space.
   assign fifo_full = (fifo_level == DEPTH_LVL);
   assign wr_en     = in_dr && !fifo_full;
   assign drop      = in_dr && fifo_full;
   assign head      = mem[rd_ptr];
   assign xfer      = out_valid && out_ready;
   assign sum       = acc + out_data;
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         out_data  <= 8'h00;
         out_valid <= 1'b0;
         acc       <= 8'h00;
         cnt       <= '0;
`ifdef PACKER_SEQ_EN
         seq       <= 8'h00;
`endif
      end else begin
         state     <= state_n;
         out_data  <= out_data_n;
         out_valid <= out_valid_n;
         acc       <= acc_n;
         cnt       <= cnt_n;
`ifdef PACKER_SEQ_EN
         seq       <= seq_n;
`endif
      end
   end

   // Every byte is loaded on the edge that transfers its predecessor, giving one byte per cycle.
   always_comb begin
      state_n     = state;
      out_data_n  = out_data;
      out_valid_n = out_valid;
      acc_n       = acc;
      cnt_n       = cnt;
      pop         = 1'b0;
`ifdef PACKER_SEQ_EN
      seq_n       = seq;
`endif
      case (state)
         ST_IDLE: begin
            if (fifo_level >= FRAME_LVL) begin
               out_data_n  = SOF_BYTE;
               out_valid_n = 1'b1;
               acc_n       = 8'h00;
               state_n     = ST_SOF;
            end
         end
         ST_SOF: begin
            if (xfer) begin
`ifdef PACKER_SEQ_EN
               out_data_n = seq;
               state_n    = ST_SEQ;
`else
               out_data_n = head;
               pop        = 1'b1;
               cnt_n      = CW'(1);
               state_n    = ST_PAYLOAD;
`endif
            end
         end
`ifdef PACKER_SEQ_EN
         ST_SEQ: begin
            if (xfer) begin
               out_data_n = head;
               pop        = 1'b1;
               cnt_n      = CW'(1);
               state_n    = ST_PAYLOAD;
            end
         end
`endif
         ST_PAYLOAD: begin
            if (xfer) begin
               acc_n = sum;
               if (cnt < FRAME_CNT) begin
                  out_data_n = head;
                  pop        = 1'b1;
                  cnt_n      = cnt + CW'(1);
               end else begin
                  out_data_n = sum;
                  state_n    = ST_CSUM;
               end
            end
         end
         ST_CSUM: begin
            if (xfer) begin
               out_valid_n = 1'b0;
               state_n     = ST_IDLE;
`ifdef PACKER_SEQ_EN
               seq_n       = seq + 8'h01;
`endif
            end
         end
         default: begin
            state_n     = ST_IDLE;
            out_valid_n = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dr_frame_packer.sv
// tb/tb_dr_frame_packer.sv - directed self-checking bench for dr_frame_packer
// Honours PACKER_SEQ_EN to expect the sequence byte and run the wrap test.
module tb_dr_frame_packer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_dr = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [4:0] fifo_level;
   logic       overflow;
   logic       ovf_clr = 1'b0;
   logic       busy;

`ifdef PACKER_SEQ_EN
   localparam int WIRE = 7;
`else
   localparam int WIRE = 6;
`endif

   typedef struct {
      logic [7:0] p [4];
      logic [7:0] csum;
   } vec_t;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         busy_bad = 0;
   logic [7:0] rx [$];
   int         rx_cyc [$];
   logic [7:0] exp_q [$];
   logic [7:0] exp_seq = 8'h00;
   logic       stall_prev = 1'b0;
   logic [7:0] stall_data = 8'h00;

   dr_frame_packer dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_dr      (in_dr),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Sampled on the falling edge: stalled bytes must hold, accepted bytes are logged.
   always @(negedge clk) begin
      if (rst && stall_prev) begin
         checks++;
         if (!out_valid || out_data !== stall_data) begin
            failures++;
            $display("FAIL stall_hold: valid=%0b data=%02h required valid=1 data=%02h",
                     out_valid, out_data, stall_data);
         end
      end
      stall_prev = rst && out_valid && !out_ready;
      stall_data = out_data;
      if (rst && out_valid && out_ready) begin
         rx.push_back(out_data);
         rx_cyc.push_back(cyc);
         if (!busy) busy_bad++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic push(input logic [7:0] d);
      in_data = d;
      in_dr   = 1'b1;
      @(posedge clk);
      #1;
      in_dr   = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_rx(input int n, input string name, output bit ok);
      int t = 0;
      while (rx.size() < n && t < 2000) begin
         tick(1);
         t++;
      end
      ok = (rx.size() >= n);
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: got %0d bytes required %0d", name, rx.size(), n);
      end
   endtask

   task automatic expect_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                               input logic [7:0] d, input logic [7:0] cs);
      exp_q.push_back(8'hA5);
`ifdef PACKER_SEQ_EN
      exp_q.push_back(exp_seq);
      exp_seq = exp_seq + 8'h01;
`endif
      exp_q.push_back(a);
      exp_q.push_back(b);
      exp_q.push_back(c);
      exp_q.push_back(d);
      exp_q.push_back(cs);
   endtask

   task automatic compare_rx(input string name);
      int n;
      chk($sformatf("%s_count", name), rx.size(), exp_q.size());
      n = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s[%0d]", name, i), rx[i], exp_q[i]);
      end
      rx.delete();
      rx_cyc.delete();
      exp_q.delete();
   endtask

   vec_t vecs [5];

   initial begin
      bit ok;
      int lp;
      logic [7:0] b;

      vecs[0].p = '{8'h01, 8'h02, 8'h03, 8'h04}; vecs[0].csum = 8'h0A;
      vecs[1].p = '{8'hFF, 8'hFF, 8'hFF, 8'h02}; vecs[1].csum = 8'hFF;
      vecs[2].p = '{8'h00, 8'h00, 8'h00, 8'h00}; vecs[2].csum = 8'h00;
      vecs[3].p = '{8'h80, 8'h80, 8'h10, 8'h20}; vecs[3].csum = 8'h30;
      vecs[4].p = '{8'h12, 8'h34, 8'h56, 8'h78}; vecs[4].csum = 8'h14;

      tick(2);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_fifo_level", fifo_level, 5'd0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b1;
      tick(1);

      out_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         for (int k = 0; k < 4; k++) push(vecs[v].p[k]);
         lp = cyc;
         wait_rx(WIRE, "vec", ok);
         if (ok) begin
            chk($sformatf("vec%0d_latency", v), rx_cyc[0], lp + 1);
            chk($sformatf("vec%0d_no_bubble", v), rx_cyc[WIRE-1] - rx_cyc[0], WIRE - 1);
         end
         expect_frame(vecs[v].p[0], vecs[v].p[1], vecs[v].p[2], vecs[v].p[3], vecs[v].csum);
         compare_rx($sformatf("vec%0d", v));
         tick(1);
         chk($sformatf("vec%0d_level_empty", v), fifo_level, 5'd0);
         chk($sformatf("vec%0d_idle", v), busy, 1'b0);
      end
      chk("busy_during_frames", busy_bad, 0);

      out_ready = 1'b0;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      for (int i = 0; i < 60 && rx.size() < WIRE; i++) begin
         out_ready = ~out_ready;
         tick(1);
      end
      out_ready = 1'b1;
      tick(4);
      expect_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'hAA);
      compare_rx("stall");

      out_ready = 1'b0;
      for (int i = 1; i <= 17; i++) push(8'(i));
      chk("full_level", fifo_level, 5'd16);
      chk("full_overflow", overflow, 1'b1);
      in_data = 8'h99; in_dr = 1'b1; ovf_clr = 1'b1;
      tick(1);
      in_dr = 1'b0; ovf_clr = 1'b0;
      chk("drop_beats_clr", overflow, 1'b1);
      chk("full_level_hold", fifo_level, 5'd16);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("ovf_cleared", overflow, 1'b0);
      out_ready = 1'b1;
      wait_rx(4 * WIRE, "drain", ok);
      for (int f = 0; f < 4; f++) begin
         b = 8'(4 * f + 1);
         expect_frame(b, b + 8'd1, b + 8'd2, b + 8'd3, 8'(16 * f + 10));
      end
      compare_rx("drain");
      tick(1);
      chk("drain_level", fifo_level, 5'd0);

      push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
      wait_rx(WIRE - 4, "pre_reset", ok);
      chk("pre_reset_busy", busy, 1'b1);
      chk("pre_reset_byte2", out_data, 8'hA2);
      rst = 1'b0;
      #1;
      chk("async_out_valid", out_valid, 1'b0);
      chk("async_fifo_level", fifo_level, 5'd0);
      chk("async_busy", busy, 1'b0);
      chk("async_out_data", out_data, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_seq = 8'h00;
      rx.delete();
      rx_cyc.delete();
      tick(1);
      push(8'h05); push(8'h06); push(8'h07); push(8'h08);
      wait_rx(WIRE, "post_reset", ok);
      expect_frame(8'h05, 8'h06, 8'h07, 8'h08, 8'h1A);
      compare_rx("post_reset");

`ifdef PACKER_SEQ_EN
      for (int f = 0; f < 257; f++) begin
         push(8'h01); push(8'h02); push(8'h03); push(8'h04);
         wait_rx(WIRE, "seq", ok);
         expect_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
         compare_rx($sformatf("seq%0d", f));
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
